// File: rtl/counter_share_arb.sv
// Round-robin arbiter that lends one shared up-counter to NREQ requesters.
// A granted requester's terminal count is latched, counted 0..term, then done is pulsed.
module counter_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   len,
  input  logic                    abort,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        cnt_q,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [1:0]              o_dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NREQ-1:0]   r_gnt;
  logic [WIDTH-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_term;
  logic [IW-1:0]     r_rr_last;
  logic [IW-1:0]     w_winner;
  logic [IW-1:0]     w_cand;
  logic              w_found;
  logic [NREQ-1:0]   w_onehot;
  logic              w_cnt_at_term;

  // Handshake: req is a level; gnt holds from LOAD through DONE, done pulses in DONE.
  // A requester may drop req after gnt; the transaction still runs to completion.

  // Search starts just past the last winner so every requester is reached within NREQ turns.
  always_comb begin
    w_winner = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IW'((int'(r_rr_last) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  assign w_onehot      = NREQ'(1'b1) << w_winner;
  assign w_cnt_at_term = (r_cnt == r_term);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_next = S_LOAD;
      S_LOAD: w_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)              w_next = S_IDLE;
        else if (w_cnt_at_term) w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_term    <= '0;
      r_rr_last <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt     <= w_onehot;
            r_rr_last <= w_winner;
            r_term    <= len[int'(w_winner)*WIDTH +: WIDTH];
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
          if (abort) r_gnt <= '0;
        end
        S_RUN: begin
          if (abort) begin
            r_gnt <= '0;
            r_cnt <= '0;
          end else if (!w_cnt_at_term) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: r_gnt <= '0;
        default: r_gnt <= '0;
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign cnt_q       = r_cnt;
  assign done        = (r_state == S_DONE) ? r_gnt : '0;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule
